// File: rtl/fp_convert_arbiter.sv
// Arbitrated integer-to-fixed-point converter: NUM_REQ requesters share one converter feeding a single result register.
// Define FPCONV_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).

module convert_to_fp #(
   parameter int INPUT_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 32,
   parameter int FBITS        = 24
) (
   input  logic [INPUT_WIDTH-1:0]  in_data,
   output logic [OUTPUT_WIDTH-1:0] out_data
);

   // Zero-extend first, so bits shifted past OUTPUT_WIDTH simply fall off (truncation).
   assign out_data = OUTPUT_WIDTH'(in_data) << FBITS;

endmodule

module fp_convert_arbiter #(
   parameter int INPUT_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 32,
   parameter int FBITS        = 24,
   parameter int NUM_REQ      = 4
) (
   input  logic                           Clk,
   input  logic                           Reset_N,
   input  logic [NUM_REQ-1:0]             Req_Valid,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0] Req_Data,
   output logic [NUM_REQ-1:0]             Req_Ready,
   output logic                           Out_Valid,
   output logic [OUTPUT_WIDTH-1:0]        Out_Data,
   output logic [2:0]                     Out_Id,
   input  logic                           Out_Ready
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e                  state_q, state_d;
   logic [OUTPUT_WIDTH-1:0] data_q, data_d;
   logic [2:0]              id_q, id_d;

   logic                    found;
   logic [2:0]              gnt_idx;
   logic [INPUT_WIDTH-1:0]  operand;
   logic [OUTPUT_WIDTH-1:0] conv_result;
   logic                    can_accept;
   logic                    transfer;

`ifdef FPCONV_ARB_RR_EN
   logic [2:0] ptr_q, ptr_d;

   // Two passes: requesters at or above the pointer first, then wrap to the bottom.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      found   = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && Req_Valid[i] && (3'(i) >= ptr_q)) begin
            found   = 1'b1;
            gnt_idx = 3'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && Req_Valid[i]) begin
            found   = 1'b1;
            gnt_idx = 3'(i);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (transfer) ptr_d = (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
   end

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end
`else
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && Req_Valid[i]) begin
            found   = 1'b1;
            gnt_idx = 3'(i);
         end
      end
   end
`endif

   assign can_accept = (state_q == EMPTY) || Out_Ready;
   assign transfer   = found && can_accept && Reset_N;

   // Grant never looks at Req_Data; the operand is merely steered by the grant.
   always_comb begin
      Req_Ready = '0;
      operand   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         Req_Ready[i] = transfer && (gnt_idx == 3'(i));
         if (gnt_idx == 3'(i)) operand = Req_Data[i*INPUT_WIDTH +: INPUT_WIDTH];
      end
   end

   convert_to_fp #(
      .INPUT_WIDTH  (INPUT_WIDTH),
      .OUTPUT_WIDTH (OUTPUT_WIDTH),
      .FBITS        (FBITS)
   ) u_convert (
      .in_data  (operand),
      .out_data (conv_result)
   );

   // Result register state: a reload while draining keeps it FULL, giving one result per cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (transfer) state_d = FULL;
         FULL:    if (transfer) state_d = FULL;
                  else if (Out_Ready) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      data_d = data_q;
      id_d   = id_q;
      if (transfer) begin
         data_d = conv_result;
         id_d   = gnt_idx;
      end
   end

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q <= EMPTY;
         // NOTE: the payload is reset too, because Out_Data and Out_Id must read zero during reset.
         data_q  <= '0;
         id_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      Out_Valid = (state_q == FULL);
      Out_Data  = data_q;
      Out_Id    = id_q;
   end

endmodule

// File: doc/fp_convert_arbiter.md
FP_CONVERT_ARBITER -- requirements
Module: fp_convert_arbiter

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 8, width of each requester's unsigned integer operand.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 32, width of the fixed-point result.
REQ-003 SHALL have parameter FBITS, default 24, number of fractional bits in the result.
REQ-004 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-005 SHALL have port Clk  input  1  the single clock; all state on rising edge.
REQ-006 SHALL have port Reset_N  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port Req_Valid  input  NUM_REQ  per-requester operand valid.
REQ-008 SHALL have port Req_Data  input  NUM_REQ*INPUT_WIDTH  operands, requester i in bits [i*INPUT_WIDTH +: INPUT_WIDTH].
REQ-009 SHALL have port Req_Ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-010 SHALL have port Out_Valid  output  1  result register holds a valid result.
REQ-011 SHALL have port Out_Data  output  OUTPUT_WIDTH  fixed-point result.
REQ-012 SHALL have port Out_Id  output  3  index of the requester that owns Out_Data.
REQ-013 SHALL have port Out_Ready  input  1  downstream accepts the result.

Function
REQ-014 SHALL share one convert_to_fp instance (same INPUT_WIDTH/OUTPUT_WIDTH/FBITS) among all requesters; operand selected by current grant.
REQ-015 Conversion: operand zero-extended, shifted left FBITS, truncated to OUTPUT_WIDTH (8'd10 -> 32'h0A00_0000).
REQ-016 Result register states: EMPTY (Out_Valid=0), FULL (Out_Valid=1).
REQ-017 Can_Accept = EMPTY or (FULL and Out_Ready).
REQ-018 Grant: one requester among those with Req_Valid=1, chosen per REQ-030/031; none if Req_Valid=0.
REQ-019 Req_Ready[g] SHALL be 1 only for the granted g and only when Can_Accept; all other bits 0; combinational from Req_Valid, state, Out_Ready.
REQ-020 Transfer on requester side occurs on a rising edge with Req_Valid[g]=1 and Req_Ready[g]=1.
REQ-021 Latency: operand transferred at edge N -> Out_Valid=1 with its result and Out_Id=g after edge N.
REQ-022 Simultaneous drain and accept (FULL, Out_Ready=1, transfer): register reloads, Out_Valid stays 1, no bubble; full throughput of one result per cycle.
REQ-023 Drain without accept: FULL -> EMPTY.
REQ-024 FULL and Out_Ready=0: Out_Data and Out_Id held stable; all Req_Ready=0.
REQ-025 Grant SHALL not depend on Req_Data; a requester may drop Req_Valid before transfer with no side effect.
REQ-026 Requesters with index >= NUM_REQ do not exist; Out_Id upper bits zero-padded.

Reset
REQ-027 Reset_N=0 SHALL immediately clear Out_Valid, Out_Data=0, Out_Id=0, round-robin pointer=0, independent of Clk.
REQ-028 While Reset_N=0 all Req_Ready=0; result pending at reset assertion is discarded.
REQ-029 First grant after Reset_N deasserts SHALL follow the pointer=0 rule.

Configuration
REQ-030 With macro FPCONV_ARB_RR_EN defined: round-robin; search starts at pointer, wraps NUM_REQ-1 -> 0; on transfer pointer = g+1 modulo NUM_REQ; pointer unchanged if no transfer.
REQ-031 Without FPCONV_ARB_RR_EN: fixed priority, lowest index wins; no pointer register.

Verification
REQ-032 Single: reset, Req_Valid=4'b0001, Req_Data[7:0]=8'h0A, Out_Ready=1 -> Req_Ready=4'b0001, next cycle Out_Valid=1, Out_Data=32'h0A00_0000, Out_Id=0.
REQ-033 Backpressure: Out_Ready=0 after one result, req 1 valid with 8'hFF -> Req_Ready=0, Out_Data held 32'h0A00_0000; raise Out_Ready -> next cycle Out_Data=32'hFF00_0000, Out_Id=1.
REQ-034 RR (macro defined): all four valid continuously, Out_Ready=1 -> Out_Id sequence 0,1,2,3,0 on consecutive cycles, Out_Valid continuously 1.
REQ-035 Fixed priority (macro undefined): same stimulus -> Out_Id 0 every cycle; req 0 dropped -> Out_Id 1.
REQ-036 Reset mid-operation: Out_Valid=1, assert Reset_N=0 between edges -> Out_Valid=0, Out_Data=0 before next edge; after release, req 2 and 3 valid -> Out_Id=2 first (RR).
REQ-037 Boundary: operand 8'h00 -> Out_Data=32'h0000_0000 with Out_Valid=1; operand 8'h80 -> 32'h8000_0000.
